// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: access-control sequencer behind the 3x4 keypad scanner.
// Captures the 4-digit BCD entry on each rising edge of the confirm level,
// checks it against the stored code and runs the unlock / fail / lockout
// sequences. While unlocked, the stored code can be reprogrammed.
module keypad_lock_ctrl #(
  parameter logic [15:0] DEFAULT_CODE = 16'h1234,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned OPEN_CYCLES  = 50000000,
  parameter int unsigned LOCK_CYCLES  = 100000000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic        submit,
  input  logic        prog_mode,
  output logic        unlock,
  output logic        alarm,
  output logic        fail_pulse,
  output logic        code_updated,
  output logic [1:0]  fail_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    CHECK   = 3'b001,
    OPEN    = 3'b010,
    FAIL    = 3'b011,
    LOCKOUT = 3'b100,
    PROGRAM = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]       FC_MAX    = 2'(MAX_TRIES);

  state_t           state_q;
  logic             submit_q;
  logic [15:0]      code_q;
  logic [15:0]      entry_q;
  logic [CNT_W-1:0] timer_q;
  logic             unlock_q;
  logic             alarm_q;
  logic             fail_pulse_q;
  logic             code_updated_q;
  logic [1:0]       fail_count_q;

  logic             sub_rise;
  logic             digits_bcd;
  logic             timer_zero;
  logic             last_try;

  // Confirm edge detect, BCD validity of the live entry, timer/try decodes.
  always_comb begin
    sub_rise   = submit & ~submit_q;
    digits_bcd = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (digits[4*i +: 4] > 4'd9) digits_bcd = 1'b0;
    end
    timer_zero = (timer_q == '0);
    last_try   = (({30'd0, fail_count_q} + 32'd1) == MAX_TRIES);
  end

  // Sequencer: state, timer, stored code and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      submit_q       <= 1'b1;
      code_q         <= DEFAULT_CODE;
      entry_q        <= '0;
      timer_q        <= '0;
      unlock_q       <= 1'b0;
      alarm_q        <= 1'b0;
      fail_pulse_q   <= 1'b0;
      code_updated_q <= 1'b0;
      fail_count_q   <= '0;
    end else begin
      submit_q       <= submit;
      fail_pulse_q   <= 1'b0;
      code_updated_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sub_rise) begin
            entry_q <= digits;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (entry_q == code_q) begin
            state_q      <= OPEN;
            fail_count_q <= '0;
            timer_q      <= OPEN_LOAD;
            unlock_q     <= 1'b1;
          end else if (last_try) begin
            state_q      <= LOCKOUT;
            fail_count_q <= FC_MAX;
            timer_q      <= LOCK_LOAD;
            alarm_q      <= 1'b1;
            fail_pulse_q <= 1'b1;
          end else begin
            state_q      <= FAIL;
            fail_count_q <= fail_count_q + 2'd1;
            fail_pulse_q <= 1'b1;
          end
        end
        FAIL: begin
          state_q <= IDLE;
        end
        OPEN: begin
          // Expiry is tested first so it wins over a coincident confirm.
          if (timer_zero) begin
            state_q  <= IDLE;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q - CNT_W'(1);
            if (sub_rise) begin
              if (!prog_mode) begin
                state_q  <= IDLE;
                unlock_q <= 1'b0;
              end else if (digits_bcd) begin
                entry_q        <= digits;
                state_q        <= PROGRAM;
                code_updated_q <= 1'b1;
              end
            end
          end
        end
        PROGRAM: begin
          code_q  <= entry_q;
          state_q <= OPEN;
          timer_q <= OPEN_LOAD;
        end
        LOCKOUT: begin
          if (timer_zero) begin
            state_q      <= IDLE;
            fail_count_q <= '0;
            alarm_q      <= 1'b0;
          end else begin
            timer_q <= timer_q - CNT_W'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          unlock_q <= 1'b0;
          alarm_q  <= 1'b0;
        end
      endcase
    end
  end

  assign unlock       = unlock_q;
  assign alarm        = alarm_q;
  assign fail_pulse   = fail_pulse_q;
  assign code_updated = code_updated_q;
  assign fail_count   = fail_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl: scoreboard bench for keypad_lock_ctrl.
// Every change on unlock/alarm/fail_pulse/code_updated/fail_count is an event
// {signal, value, cycle}; expected events are queued in time order when the
// stimulus is driven and popped as the monitor observes changes.
module tb_keypad_lock_ctrl;

  localparam int unsigned OPEN_N = 8;
  localparam int unsigned LOCK_N = 16;
  localparam int unsigned TRIES  = 3;

  localparam int unsigned S_UNL = 0;
  localparam int unsigned S_ALM = 1;
  localparam int unsigned S_FP  = 2;
  localparam int unsigned S_CU  = 3;
  localparam int unsigned S_FC  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic        submit = 1'b1;
  logic        prog_mode = 1'b0;
  logic        unlock;
  logic        alarm;
  logic        fail_pulse;
  logic        code_updated;
  logic [1:0]  fail_count;
  logic [2:0]  state_dbg;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_code = 16'h1234;
  int unsigned exp_fc = 0;

  logic [3:0]  prev_v [5] = '{default: 4'd0};
  logic [3:0]  mon_cur [5];
  logic [31:0] mon_got;
  logic [31:0] mon_exp;

  keypad_lock_ctrl #(
    .DEFAULT_CODE(16'h1234),
    .MAX_TRIES   (TRIES),
    .OPEN_CYCLES (OPEN_N),
    .LOCK_CYCLES (LOCK_N),
    .CNT_W       (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits      (digits),
    .submit      (submit),
    .prog_mode   (prog_mode),
    .unlock      (unlock),
    .alarm       (alarm),
    .fail_pulse  (fail_pulse),
    .code_updated(code_updated),
    .fail_count  (fail_count),
    .state_dbg   (state_dbg)
  );

  initial forever #5 clk = ~clk;

  // Count of active clock edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [27:0] ev_key(input logic [31:0] e);
    return {e[23:0], e[31:28]};
  endfunction

  function automatic void push_exp(input int unsigned sig, input int unsigned val, input int c);
    logic [31:0] e;
    int          i;
    e = {4'(sig), 4'(val), 24'(c)};
    i = 0;
    while (i < exp_q.size() && ev_key(exp_q[i]) <= ev_key(e)) i++;
    exp_q.insert(i, e);
  endfunction

  function automatic string evt_name(input int s);
    case (s)
      0:       return "unlock_evt";
      1:       return "alarm_evt";
      2:       return "fail_pulse_evt";
      3:       return "code_updated_evt";
      default: return "fail_count_evt";
    endcase
  endfunction

  // Monitor: turn output changes into events and compare with the scoreboard.
  always @(negedge clk) begin
    mon_cur[0] = {3'b0, unlock};
    mon_cur[1] = {3'b0, alarm};
    mon_cur[2] = {3'b0, fail_pulse};
    mon_cur[3] = {3'b0, code_updated};
    mon_cur[4] = {2'b0, fail_count};
    for (int s = 0; s < 5; s++) begin
      if (mon_cur[s] !== prev_v[s]) begin
        mon_got = {4'(s), mon_cur[s], 24'(cyc)};
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event", mon_got, '1);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq(evt_name(s), mon_got, mon_exp);
        end
        prev_v[s] = mon_cur[s];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic press(input logic [15:0] d, input int hold);
    digits = d;
    submit = 1'b1;
    repeat (hold) step();
    submit = 1'b0;
  endtask

  // Submit an entry from IDLE, queueing the reaction predicted by the model.
  task automatic enter(input logic [15:0] d, input int hold, output int t0);
    t0 = cyc;
    if (d == exp_code) begin
      push_exp(S_UNL, 1, t0 + 2);
      if (exp_fc != 0) push_exp(S_FC, 0, t0 + 2);
      exp_fc = 0;
    end else if (exp_fc + 1 == TRIES) begin
      push_exp(S_FP, 1, t0 + 2);
      push_exp(S_FP, 0, t0 + 3);
      push_exp(S_ALM, 1, t0 + 2);
      push_exp(S_ALM, 0, t0 + 2 + LOCK_N);
      push_exp(S_FC, TRIES, t0 + 2);
      push_exp(S_FC, 0, t0 + 2 + LOCK_N);
      exp_fc = 0;
    end else begin
      exp_fc++;
      push_exp(S_FP, 1, t0 + 2);
      push_exp(S_FP, 0, t0 + 3);
      push_exp(S_FC, exp_fc, t0 + 2);
    end
    press(d, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, u, s, r;
    #1 rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_unlock", unlock, 0);
    check_eq("rst_alarm", alarm, 0);
    check_eq("rst_fail_pulse", fail_pulse, 0);
    check_eq("rst_code_updated", code_updated, 0);
    check_eq("rst_fail_count", fail_count, 0);
    check_eq("rst_state", state_dbg, 0);

    // Submit held high across reset release must not start a check.
    rst_n = 1'b1;
    repeat (4) step();
    check_eq("held_submit_state", state_dbg, 0);
    submit = 1'b0;
    repeat (2) step();

    // Correct code with submit held 3 cycles: one check, OPEN_N cycles open.
    enter(16'h1234, 3, t);
    check_eq("t1_open_state", state_dbg, 2);
    push_exp(S_UNL, 0, t + 2 + OPEN_N);
    wait_until(t + 3 + OPEN_N);

    // Two wrong entries accumulate, then a correct one clears the count.
    enter(16'h0000, 1, t);
    wait_until(t + 4);
    enter(16'h0000, 1, t);
    wait_until(t + 4);
    check_eq("t2_fail_count", fail_count, 2);
    enter(16'h1234, 1, t);
    push_exp(S_UNL, 0, t + 2 + OPEN_N);
    wait_until(t + 3 + OPEN_N);

    // Three wrong entries: lockout, submits ignored while alarmed.
    enter(16'h9999, 1, t);
    wait_until(t + 4);
    enter(16'h9999, 1, t);
    wait_until(t + 4);
    enter(16'h9999, 1, t);
    wait_until(t + 3);
    check_eq("t3_alarm", alarm, 1);
    press(16'h1234, 1);
    step();
    press(16'h1234, 2);
    wait_until(t + 3 + LOCK_N);
    check_eq("t3_idle_state", state_dbg, 0);

    // Reprogram to 0420 while open; timer reloads after the program cycle.
    enter(16'h1234, 1, t);
    u = t + 2;
    wait_until(u + 2);
    prog_mode = 1'b1;
    s = cyc;
    push_exp(S_CU, 1, s + 1);
    push_exp(S_CU, 0, s + 2);
    push_exp(S_UNL, 0, s + 2 + OPEN_N);
    press(16'h0420, 1);
    check_eq("t4_prog_state", state_dbg, 5);
    prog_mode = 1'b0;
    exp_code = 16'h0420;
    wait_until(s + 3 + OPEN_N);
    enter(16'h1234, 1, t);
    wait_until(t + 4);
    enter(16'h0420, 1, t);
    push_exp(S_UNL, 0, t + 2 + OPEN_N);
    wait_until(t + 3 + OPEN_N);

    // Non-BCD program entry is ignored; original expiry stands.
    enter(16'h0420, 1, t);
    u = t + 2;
    wait_until(u + 2);
    prog_mode = 1'b1;
    press(16'h12A4, 1);
    prog_mode = 1'b0;
    push_exp(S_UNL, 0, u + OPEN_N);
    wait_until(u + OPEN_N + 1);

    // Code still 0420; a plain submit while open relocks immediately.
    enter(16'h0420, 1, t);
    u = t + 2;
    wait_until(u + 1);
    s = cyc;
    push_exp(S_UNL, 0, s + 1);
    press(16'h0000, 1);
    wait_until(s + 3);

    // Program confirm coinciding with timer expiry: expiry wins.
    enter(16'h0420, 1, t);
    u = t + 2;
    wait_until(u + OPEN_N - 1);
    prog_mode = 1'b1;
    press(16'h1111, 1);
    prog_mode = 1'b0;
    push_exp(S_UNL, 0, u + OPEN_N);
    wait_until(u + OPEN_N + 2);
    enter(16'h1111, 1, t);
    wait_until(t + 4);
    enter(16'h0420, 1, t);
    push_exp(S_UNL, 0, t + 2 + OPEN_N);
    wait_until(t + 3 + OPEN_N);

    // Reset while open: unlock drops at once, code returns to default.
    enter(16'h0420, 1, t);
    u = t + 2;
    wait_until(u + 3);
    r = cyc;
    push_exp(S_UNL, 0, r);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_unlock", unlock, 0);
    check_eq("t6_rst_state", state_dbg, 0);
    step();
    step();
    rst_n = 1'b1;
    exp_code = 16'h1234;
    exp_fc = 0;
    repeat (2) step();
    enter(16'h0420, 1, t);
    wait_until(t + 4);
    enter(16'h1234, 1, t);
    push_exp(S_UNL, 0, t + 2 + OPEN_N);
    wait_until(t + 3 + OPEN_N);

    repeat (3) step();
    check_eq("pending_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
